plot_clip_fifo: RTL and testbench
=================================

# plot_clip_fifo

Pixel post-processor between the circle-drawing engine and the VGA adapter's plot port. Accepts signed pixel coordinates from the engine, which can fall outside the 160×120 screen for circles near an edge, and discards off-screen pixels with a saturating drop count. Queues on-screen pixels in a small first-word-fall-through FIFO and presents them to the adapter with a valid/ready handshake, so the engine never writes out-of-range addresses into the framebuffer.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of FIFO and drop_count
- in_x  in  10  signed two's-complement x
- in_y  in  9  signed two's-complement y
- in_colour  in  3  pixel colour
- in_valid  in  1  input pixel present
- in_ready  out  1  block can accept; equals !full
- out_x  out  8  on-screen x, 0..SCREEN_W-1
- out_y  out  7  on-screen y, 0..SCREEN_H-1
- out_colour  out  3  colour
- out_plot  out  1  output pixel valid; equals !empty
- out_ready  in  1  adapter consumes the head pixel
- drop_count  out  16  number of off-screen pixels discarded; saturates at 16'hFFFF

## Operation
- Input transfer: in_valid && in_ready on a rising edge.
- Clip test on each transfer: on-screen iff 0 ≤ in_x < SCREEN_W and 0 ≤ in_y < SCREEN_H, compared signed.
- On-screen transfer: push {in_x[7:0], in_y[6:0], in_colour}.
- Off-screen transfer: consumed, not pushed; drop_count += 1 unless already 16'hFFFF.
- in_ready depends only on state: !full. No combinational path from in_* to in_ready.
- Output transfer: out_plot && out_ready pops the head entry.
- out_x, out_y and out_colour are forced to 0 whenever out_plot = 0.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full: in_ready = 0, so no push. A pop in that cycle frees one slot, and in_ready rises the next cycle.
- Empty: no pop is possible. A push in that cycle raises out_plot the next cycle.
- clear: count, read pointer, write pointer and drop_count all go to 0. clear overrides any push, pop or drop in the same cycle. That cycle's input transfer is lost, and the lost pixel is not counted.
- Pointers wrap modulo DEPTH. count width is $clog2(DEPTH)+1.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - count 0 and pointers 0
  - out_plot 0 and out_x/out_y/out_colour 0
  - in_ready 1
  - drop_count 0
- Reset mid-operation discards all queued pixels. The FIFO storage array itself is not reset.
- Latency: an accepted on-screen pixel appears on out_* one cycle after acceptance when the FIFO was empty. There is no bypass.
- Throughput: one pixel per cycle in and out, sustained, when out_ready stays high.
- drop_count updates one cycle after the off-screen transfer.
- Output data changes only after a pop or a push-into-empty. It is stable while out_plot = 1 and out_ready = 0.

## Structure
- Package `pixel_pkg`:
  - SCREEN_W and SCREEN_H localparams
  - `pixel_t` packed struct {x[7:0], y[6:0], colour[2:0]}
  - shared by the circle engine, this block and its benches
- Sub-module `sync_fifo`:
  - generic FWFT FIFO parameterised on DEPTH and element type
  - ports: push, pop, wdata, rdata, full, empty, count
  - used by this block for storage
- Clipping, handshake and drop_count logic live in plot_clip_fifo itself.

## Test plan
- Reset, then push (10, 20, colour 3'b010) with out_ready = 1 → next cycle out_plot = 1 with out_x = 10, out_y = 20, out_colour = 2. The following cycle out_plot = 0 and out_* = 0.
- Push (−1, 5), (160, 5), (5, 120) and (159, 119) → drop_count = 3. Exactly one output: (159, 119).
- out_ready = 0, push 9 on-screen pixels → in_ready falls after the 8th accept. The 9th is held off. Releasing out_ready drains all 9 in order, and in_ready returns one cycle after the first pop.
- Full FIFO, simultaneous in_valid and pop → no push that cycle and count = 7. The next cycle in_ready = 1, then push and pop together keep count at 7 with order preserved.
- Force drop_count to 16'hFFFE via 2^16−2 off-screen pushes, then push 3 more off-screen → stays at 16'hFFFF. clear → drop_count = 0 and out_plot = 0.
- Assert rst_n = 0 mid-stream with 5 entries queued → out_plot, out_* and drop_count go to 0 immediately. in_ready = 1.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel definitions for the circle engine, the plot clip FIFO and their benches.
package pixel_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // One on-screen pixel as stored in the plot queue and presented to the VGA adapter.
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

endpackage

// File: rtl/plot_clip_fifo_if.sv
// Pixel stream between the circle engine (master) and the plot clip FIFO (slave),
// including the adapter-side plot handshake and the drop counter.
interface plot_clip_fifo_if;

    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic        out_plot;
    logic        out_ready;
    logic [15:0] drop_count;

    modport slave (
        input  in_x, in_y, in_colour, in_valid, out_ready,
        output in_ready, out_x, out_y, out_colour, out_plot, drop_count
    );

    modport master (
        output in_x, in_y, in_colour, in_valid, out_ready,
        input  in_ready, out_x, out_y, out_colour, out_plot, drop_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO: rdata always shows the head entry.
// Push is ignored when full, pop is ignored when empty, clear flushes synchronously.
module sync_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push_en;
    logic           pop_en;

    assign push_en = push && !full && !clear;
    assign pop_en  = pop && !empty && !clear;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/plot_clip_fifo.sv
// Clips signed engine pixels to the visible screen, counts discarded pixels
// (saturating) and queues visible ones for the VGA adapter's plot port.
module plot_clip_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = pixel_pkg::SCREEN_W,
    parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    plot_clip_fifo_if.slave  bus
);

    import pixel_pkg::*;

    pixel_t                 wr_px;
    pixel_t                 rd_px;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   in_xfer;
    logic                   on_screen;
    logic                   pop;

    // Sign bit set means negative; otherwise an unsigned compare against the limit suffices.
    assign on_screen = !bus.in_x[9] && (bus.in_x < 10'(SCREEN_W)) &&
                       !bus.in_y[8] && (bus.in_y < 9'(SCREEN_H));

    assign bus.in_ready = !full;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_plot && bus.out_ready;

    assign wr_px.x      = bus.in_x[7:0];
    assign wr_px.y      = bus.in_y[6:0];
    assign wr_px.colour = bus.in_colour;

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (pixel_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (in_xfer && on_screen),
        .pop   (pop),
        .wdata (wr_px),
        .rdata (rd_px),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bus.out_plot   = !empty;
    assign bus.out_x      = empty ? '0 : rd_px.x;
    assign bus.out_y      = empty ? '0 : rd_px.y;
    assign bus.out_colour = empty ? '0 : rd_px.colour;

    // Saturating count of off-screen pixels consumed; clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.drop_count <= '0;
        end else if (clear) begin
            bus.drop_count <= '0;
        end else if (in_xfer && !on_screen && (bus.drop_count != '1)) begin
            bus.drop_count <= bus.drop_count + 16'd1;
        end
    end

    a_empty_matches_count: assert property (
        @(posedge clk) disable iff (!rst_n) empty == (fifo_count == '0)
    );

endmodule

// File: tb/tb_plot_clip_fifo.sv
// Self-checking bench for plot_clip_fifo: clip vector table, handshake corner
// sequences, drop counter saturation, async reset and randomized traffic
// against a queue-based reference model.
module tb_plot_clip_fifo;

    import pixel_pkg::*;

    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    plot_clip_fifo_if bus();

    plot_clip_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    pixel_t mq[$];
    int     mdrops = 0;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
        bit         exp_on;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_on(input logic [9:0] x, input logic [8:0] y);
        int xi;
        int yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        return (xi >= 0) && (xi < SCREEN_W) && (yi >= 0) && (yi < SCREEN_H);
    endfunction

    task automatic set_in(input bit v, input int x, input int y, input int c, input bit rdy);
        bus.in_valid  = v;
        bus.in_x      = 10'(x);
        bus.in_y      = 9'(y);
        bus.in_colour = 3'(c);
        bus.out_ready = rdy;
    endtask

    task automatic check_model();
        bit has;
        has = (mq.size() != 0);
        chk("m_out_plot",   32'(bus.out_plot),   32'(has));
        chk("m_in_ready",   32'(bus.in_ready),   32'(mq.size() < DEPTH));
        chk("m_drop_count", 32'(bus.drop_count), 32'(mdrops));
        chk("m_out_x",      32'(bus.out_x),      has ? 32'(mq[0].x) : 32'd0);
        chk("m_out_y",      32'(bus.out_y),      has ? 32'(mq[0].y) : 32'd0);
        chk("m_out_colour", 32'(bus.out_colour), has ? 32'(mq[0].colour) : 32'd0);
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic tick();
        bit     acc;
        bit     pop;
        bit     on;
        pixel_t px;
        check_model();
        acc       = bus.in_valid && (mq.size() < DEPTH);
        pop       = (mq.size() != 0) && bus.out_ready;
        on        = model_on(bus.in_x, bus.in_y);
        px.x      = bus.in_x[7:0];
        px.y      = bus.in_y[6:0];
        px.colour = bus.in_colour;
        @(posedge clk);
        if (clear) begin
            mq.delete();
            mdrops = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (on) mq.push_back(px);
                else if (mdrops < 65535) mdrops++;
            end
        end
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int exp_drops;
        int exp_idx;

        vt[0]  = '{-1,   5,   3'd1, 1'b0};
        vt[1]  = '{160,  5,   3'd2, 1'b0};
        vt[2]  = '{5,    120, 3'd3, 1'b0};
        vt[3]  = '{159,  119, 3'd4, 1'b1};
        vt[4]  = '{0,    0,   3'd5, 1'b1};
        vt[5]  = '{0,    -1,  3'd6, 1'b0};
        vt[6]  = '{-512, 10,  3'd7, 1'b0};
        vt[7]  = '{511,  255, 3'd0, 1'b0};
        vt[8]  = '{159,  0,   3'd1, 1'b1};
        vt[9]  = '{0,    119, 3'd2, 1'b1};
        vt[10] = '{160,  119, 3'd3, 1'b0};
        vt[11] = '{-1,   -1,  3'd4, 1'b0};

        set_in(0, 0, 0, 0, 0);
        #2;
        chk("rst_out_plot",   32'(bus.out_plot),   32'd0);
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
        chk("rst_out_x",      32'(bus.out_x),      32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel latency and return to empty.
        set_in(1, 10, 20, 2, 1);
        tick();
        chk("t1_plot",   32'(bus.out_plot),   32'd1);
        chk("t1_x",      32'(bus.out_x),      32'd10);
        chk("t1_y",      32'(bus.out_y),      32'd20);
        chk("t1_colour", 32'(bus.out_colour), 32'd2);
        set_in(0, 0, 0, 0, 1);
        tick();
        chk("t1_plot_off", 32'(bus.out_plot),   32'd0);
        chk("t1_x_zero",   32'(bus.out_x),      32'd0);
        chk("t1_y_zero",   32'(bus.out_y),      32'd0);
        chk("t1_c_zero",   32'(bus.out_colour), 32'd0);

        // Clip boundary table.
        do_clear();
        exp_drops = 0;
        for (int i = 0; i < 12; i++) begin
            set_in(1, vt[i].x, vt[i].y, vt[i].c, 1);
            tick();
            set_in(0, 0, 0, 0, 1);
            chk("vec_plot", 32'(bus.out_plot), 32'(vt[i].exp_on));
            if (vt[i].exp_on) begin
                chk("vec_x",      32'(bus.out_x),      32'(vt[i].x));
                chk("vec_y",      32'(bus.out_y),      32'(vt[i].y));
                chk("vec_colour", 32'(bus.out_colour), 32'(vt[i].c));
            end else begin
                exp_drops++;
            end
            tick();
        end
        chk("vec_drop_count", 32'(bus.drop_count), 32'(exp_drops));

        // Fill with 9 pixels while the adapter stalls, then drain in order.
        do_clear();
        for (int i = 0; i < 9; i++) begin
            set_in(1, i, i + 1, i % 8, 0);
            chk("fill_in_ready", 32'(bus.in_ready), 32'(i < 8));
            tick();
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        chk("rel_x0", 32'(bus.out_x), 32'd0);
        tick();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_x1", 32'(bus.out_x), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_idx = 2;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_plot) begin
                chk("drain_x", 32'(bus.out_x), 32'(exp_idx));
                chk("drain_y", 32'(bus.out_y), 32'(exp_idx + 1));
                exp_idx++;
            end
            tick();
        end
        chk("drain_total", 32'(exp_idx), 32'd9);

        // Full FIFO with simultaneous input and pop, then steady push+pop at count 7.
        do_clear();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 20 + i, 0, 1, 0);
            tick();
        end
        set_in(1, 28, 0, 1, 1);
        chk("fp_in_ready_full", 32'(bus.in_ready), 32'd0);
        tick();
        chk("fp_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("fp_head21", 32'(bus.out_x), 32'd21);
        tick();
        chk("fp_head22", 32'(bus.out_x), 32'd22);
        chk("fp_ready7", 32'(bus.in_ready), 32'd1);
        set_in(1, 29, 0, 1, 1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 23; i <= 29; i++) begin
            chk("fp_order", 32'(bus.out_x), 32'(i));
            tick();
        end
        chk("fp_empty", 32'(bus.out_plot), 32'd0);

        // Drop counter saturation.
        do_clear();
        set_in(1, -1, 0, 0, 1);
        repeat (65534) @(posedge clk);
        #1;
        mdrops = 65534;
        chk("sat_fffe", 32'(bus.drop_count), 32'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", 32'(bus.drop_count), 32'hFFFF);
        set_in(1, 5, 5, 1, 1);
        do_clear();
        chk("clr_drop", 32'(bus.drop_count), 32'd0);
        chk("clr_plot", 32'(bus.out_plot),   32'd0);
        set_in(0, 0, 0, 0, 0);

        // Asynchronous reset with five pixels queued.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 40 + i, 50, 3, 0);
            tick();
        end
        set_in(1, 200, 50, 3, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("ar_plot",   32'(bus.out_plot),   32'd0);
        chk("ar_x",      32'(bus.out_x),      32'd0);
        chk("ar_y",      32'(bus.out_y),      32'd0);
        chk("ar_colour", 32'(bus.out_colour), 32'd0);
        chk("ar_drop",   32'(bus.drop_count), 32'd0);
        chk("ar_ready",  32'(bus.in_ready),   32'd1);
        mq.delete();
        mdrops = 0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            set_in($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 219)) - 20,
                   int'($urandom_range(0, 159)) - 20,
                   $urandom_range(0, 7),
                   $urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 63) == 0);
            tick();
        end
        clear = 1'b0;
        set_in(0, 0, 0, 0, 1);
        repeat (DEPTH + 1) tick();
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
